// File: rtl/alumux.sv
// ALU operand mux select encodings.
package alumux;
  typedef enum logic {
    rs1_out = 1'b0,
    pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    i_imm   = 3'b000,
    u_imm   = 3'b001,
    b_imm   = 3'b010,
    s_imm   = 3'b011,
    j_imm   = 3'b100,
    rs2_out = 3'b101
  } alumux2_sel_t;
endpackage

// File: rtl/cmpmux.sv
// Comparator second-operand mux select encoding.
package cmpmux;
  typedef enum logic {
    rs2_out = 1'b0,
    i_imm   = 1'b1
  } cmpmux_sel_t;
endpackage

// File: rtl/marmux.sv
// MAR input mux select encoding.
package marmux;
  typedef enum logic {
    pc_out  = 1'b0,
    alu_out = 1'b1
  } marmux_sel_t;
endpackage

// File: rtl/pcmux.sv
// PC input mux select encoding.
package pcmux;
  typedef enum logic [1:0] {
    pc_plus4 = 2'b00,
    alu_out  = 2'b01,
    alu_mod2 = 2'b10
  } pcmux_sel_t;
endpackage

// File: rtl/regfilemux.sv
// Register file write-data mux select encoding.
package regfilemux;
  typedef enum logic [3:0] {
    alu_out  = 4'd0,
    br_en    = 4'd1,
    u_imm    = 4'd2,
    lw       = 4'd3,
    pc_plus4 = 4'd4,
    lb       = 4'd5,
    lbu      = 4'd6,
    lh       = 4'd7,
    lhu      = 4'd8
  } regfilemux_sel_t;
endpackage

// File: rtl/rv32i_types.sv
// Shared rv32i encodings: opcodes, funct3 groups and ALU operations.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    add  = 3'b000,
    sll  = 3'b001,
    slt  = 3'b010,
    sltu = 3'b011,
    axor = 3'b100,
    sr   = 3'b101,
    aor  = 3'b110,
    aand = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  // Encoded so that funct3 maps straight onto the op for add/sll/xor/or/and
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

endpackage

// File: rtl/control_fsm.sv
// Multicycle rv32i control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional CTRL_ILLEGAL_HALT_EN sends unrecognised opcodes to a sticky HALT state instead of a NOP.
module control_fsm
  import rv32i_types::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  rv32i_opcode                       opcode,
  input  logic [2:0]                        funct3,
  input  logic [6:0]                        funct7,
  input  logic                              br_en,
  input  logic [1:0]                        mem_addr_bits,
  input  logic                              mem_resp,
  output alu_ops                            aluop,
  output logic                              load_ir,
  output logic                              load_mar,
  output logic                              load_pc,
  output logic                              load_regfile,
  output logic                              load_mdr,
  output logic                              load_data_out,
  output cmpmux::cmpmux_sel_t               cmpmux_sel,
  output pcmux::pcmux_sel_t                 pcmux_sel,
  output marmux::marmux_sel_t               marmux_sel,
  output alumux::alumux1_sel_t              alumux1_sel,
  output alumux::alumux2_sel_t              alumux2_sel,
  output regfilemux::regfilemux_sel_t       regfilemux_sel,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [3:0]                        rmask,
  output logic [3:0]                        wmask,
  output logic                              halted
);

  typedef enum logic [3:0] {
    FETCH1, FETCH2, DECODE, IMM, REG, LUI, AUIPC, BR,
    JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2, HALT
  } state_t;

  state_t     state, next_state;
  logic [3:0] load_mask, store_mask;
  logic [5:0] unused_funct7;

  assign unused_funct7 = {funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH1;
    else     state <= next_state;
  end

  // Sub-word masks shift within the 4-bit lane; misaligned accesses simply truncate
  always_comb begin
    case (load_funct3_t'(funct3))
      lw:       load_mask = 4'b1111;
      lh, lhu:  load_mask = 4'b0011 << mem_addr_bits;
      default:  load_mask = 4'b0001 << mem_addr_bits;
    endcase
    case (store_funct3_t'(funct3))
      sw:       store_mask = 4'b1111;
      sh:       store_mask = 4'b0011 << mem_addr_bits;
      default:  store_mask = 4'b0001 << mem_addr_bits;
    endcase
  end

  always_comb begin
    next_state     = state;
    aluop          = alu_add;
    load_ir        = 1'b0;
    load_mar       = 1'b0;
    load_pc        = 1'b0;
    load_regfile   = 1'b0;
    load_mdr       = 1'b0;
    load_data_out  = 1'b0;
    cmpmux_sel     = cmpmux::rs2_out;
    pcmux_sel      = pcmux::pc_plus4;
    marmux_sel     = marmux::pc_out;
    alumux1_sel    = alumux::rs1_out;
    alumux2_sel    = alumux::i_imm;
    regfilemux_sel = regfilemux::alu_out;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    rmask          = 4'b0000;
    wmask          = 4'b0000;
    halted         = 1'b0;

    case (state)
      FETCH1: begin
        load_mar   = 1'b1;
        next_state = FETCH2;
      end

      FETCH2: begin
        mem_read = 1'b1;
        load_ir  = 1'b1;
        if (mem_resp) next_state = DECODE;
      end

      DECODE: begin
        case (opcode)
          op_imm:            next_state = IMM;
          op_reg:            next_state = REG;
          op_lui:            next_state = LUI;
          op_auipc:          next_state = AUIPC;
          op_br:             next_state = BR;
          op_jal:            next_state = JAL;
          op_jalr:           next_state = JALR;
          op_load, op_store: next_state = CALC_ADDR;
`ifdef CTRL_ILLEGAL_HALT_EN
          default:           next_state = HALT;
`else
          default:           next_state = ST2;
`endif
        endcase
      end

      // Register-immediate and register-register share decoding; only operand sources differ
      IMM, REG: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        if (state == REG) alumux2_sel = alumux::rs2_out;
        case (arith_funct3_t'(funct3))
          slt, sltu: begin
            regfilemux_sel = regfilemux::br_en;
            if (state == IMM) cmpmux_sel = cmpmux::i_imm;
          end
          sr:      aluop = funct7[5] ? alu_sra : alu_srl;
          add:     aluop = (state == REG && funct7[5]) ? alu_sub : alu_add;
          default: aluop = alu_ops'(funct3);
        endcase
        next_state = FETCH1;
      end

      LUI: begin
        regfilemux_sel = regfilemux::u_imm;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        next_state     = FETCH1;
      end

      AUIPC: begin
        alumux1_sel  = alumux::pc_out;
        alumux2_sel  = alumux::u_imm;
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        next_state   = FETCH1;
      end

      BR: begin
        alumux1_sel = alumux::pc_out;
        alumux2_sel = alumux::b_imm;
        pcmux_sel   = br_en ? pcmux::alu_out : pcmux::pc_plus4;
        load_pc     = 1'b1;
        next_state  = FETCH1;
      end

      JAL: begin
        alumux1_sel    = alumux::pc_out;
        alumux2_sel    = alumux::j_imm;
        pcmux_sel      = pcmux::alu_out;
        regfilemux_sel = regfilemux::pc_plus4;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        next_state     = FETCH1;
      end

      JALR: begin
        alumux2_sel    = alumux::i_imm;
        pcmux_sel      = pcmux::alu_mod2;
        regfilemux_sel = regfilemux::pc_plus4;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        next_state     = FETCH1;
      end

      CALC_ADDR: begin
        load_mar   = 1'b1;
        marmux_sel = marmux::alu_out;
        if (opcode == op_store) begin
          alumux2_sel   = alumux::s_imm;
          load_data_out = 1'b1;
          next_state    = ST1;
        end else begin
          next_state = LD1;
        end
      end

      LD1: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
        rmask    = load_mask;
        if (mem_resp) next_state = LD2;
      end

      LD2: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        rmask        = load_mask;
        case (load_funct3_t'(funct3))
          lb:      regfilemux_sel = regfilemux::lb;
          lbu:     regfilemux_sel = regfilemux::lbu;
          lh:      regfilemux_sel = regfilemux::lh;
          lhu:     regfilemux_sel = regfilemux::lhu;
          default: regfilemux_sel = regfilemux::lw;
        endcase
        next_state = FETCH1;
      end

      ST1: begin
        mem_write = 1'b1;
        wmask     = store_mask;
        if (mem_resp) next_state = ST2;
      end

      ST2: begin
        load_pc    = 1'b1;
        next_state = FETCH1;
      end

      // Sticky until reset; unreachable when the halt option is compiled out
      HALT: begin
`ifdef CTRL_ILLEGAL_HALT_EN
        halted     = 1'b1;
        next_state = HALT;
`else
        next_state = FETCH1;
`endif
      end

      default: next_state = FETCH1;
    endcase
  end

endmodule
